// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the cache/memory port arbiter.
// Cache RTL uses the same LINE/WORD widths.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned LINE_W_DEF = 128;
    localparam int unsigned WORD_W_DEF = 32;

    typedef enum logic [2:0] {
        IDLE,
        I_READ,
        D_READ,
        D_WRITE,
        RESP
    } arb_state_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_I,
        SRC_D_RD,
        SRC_D_WR
    } arb_src_t;

    function automatic logic isBusy(input arb_state_t s);
        return (s == I_READ) || (s == D_READ) || (s == D_WRITE);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at MAX once reached.
module sat_counter
    import mem_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MAX   = 15
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge Clk) begin
        if (Rst || clr) begin
            count <= '0;
        end else if (inc && (count != WIDTH'(MAX))) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory line port between icache fills and dcache
// fills/write-throughs; every output is a register.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned LINE_W   = LINE_W_DEF,
    parameter int unsigned WORD_W   = WORD_W_DEF,
    parameter int unsigned FAIR_MAX = 4,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              i_readmiss,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_abort,
    output logic              i_readready,
    output logic [LINE_W-1:0] i_data,
    input  logic              d_readmiss,
    input  logic              d_writethru,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic              d_readready,
    output logic              d_writeready,
    output logic [LINE_W-1:0] d_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              mem_abort,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              timeout_err
);

    localparam int unsigned SW   = (FAIR_MAX > 0) ? $clog2(FAIR_MAX + 1) : 1;
    localparam int unsigned BW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned BMAX = (TIMEOUT > 0) ? TIMEOUT : 1;

    arb_state_t        state;
    arb_state_t        stateNext;
    arb_src_t          grant;
    logic [SW-1:0]     dStreak;
    logic [BW-1:0]     busyCnt;
    logic              busy;
    logic              streakInc;
    logic              streakClr;

    logic              iReadyNext;
    logic              dReadyNext;
    logic              dWriteReadyNext;
    logic              memReadNext;
    logic              memWriteNext;
    logic              memAbortNext;
    logic              timeoutNext;
    logic [LINE_W-1:0] iDataNext;
    logic [LINE_W-1:0] dDataNext;
    logic [ADDR_W-1:0] memAddrNext;
    logic [WORD_W-1:0] memWdataNext;

    assign busy = isBusy(state);

    sat_counter #(
        .WIDTH (SW),
        .MAX   (FAIR_MAX)
    ) streakCounter (
        .Clk   (Clk),
        .Rst   (Rst),
        .inc   (streakInc),
        .clr   (streakClr),
        .count (dStreak)
    );

    // Cleared in IDLE/RESP, so each busy state starts counting from zero.
    sat_counter #(
        .WIDTH (BW),
        .MAX   (BMAX)
    ) busyCounter (
        .Clk   (Clk),
        .Rst   (Rst),
        .inc   (busy),
        .clr   (!busy),
        .count (busyCnt)
    );

    always_comb begin
        stateNext       = state;
        grant           = SRC_NONE;
        streakInc       = 1'b0;
        streakClr       = 1'b0;
        iReadyNext      = 1'b0;
        dReadyNext      = 1'b0;
        dWriteReadyNext = 1'b0;
        memAbortNext    = 1'b0;
        memReadNext     = mem_read;
        memWriteNext    = mem_write;
        iDataNext       = i_data;
        dDataNext       = d_data;
        memAddrNext     = mem_addr;
        memWdataNext    = mem_wdata;
        timeoutNext     = timeout_err
                        | ((TIMEOUT != 0) && busy && (busyCnt == BW'(TIMEOUT - 1)));

        case (state)
            IDLE: begin
                if (i_readmiss && (dStreak == SW'(FAIR_MAX))) begin
                    grant = SRC_I;
                end else if (d_writethru) begin
                    grant = SRC_D_WR;
                end else if (d_readmiss) begin
                    grant = SRC_D_RD;
                end else if (i_readmiss) begin
                    grant = SRC_I;
                end

                case (grant)
                    SRC_I: begin
                        stateNext   = I_READ;
                        memAddrNext = i_addr;
                        memReadNext = 1'b1;
                        streakClr   = 1'b1;
                    end
                    SRC_D_WR: begin
                        stateNext    = D_WRITE;
                        memAddrNext  = d_addr;
                        memWdataNext = d_wdata;
                        memWriteNext = 1'b1;
                        streakInc    = i_readmiss;
                        streakClr    = !i_readmiss;
                    end
                    SRC_D_RD: begin
                        stateNext   = D_READ;
                        memAddrNext = d_addr;
                        memReadNext = 1'b1;
                        streakInc   = i_readmiss;
                        streakClr   = !i_readmiss;
                    end
                    default: ;
                endcase
            end

            I_READ: begin
                // Abort is checked first so a coincident mem_ready is discarded.
                if (i_abort) begin
                    memAbortNext = 1'b1;
                    memReadNext  = 1'b0;
                    stateNext    = IDLE;
                end else if (mem_ready) begin
                    iDataNext   = mem_rdata;
                    memReadNext = 1'b0;
                    iReadyNext  = 1'b1;
                    stateNext   = RESP;
                end
            end

            D_READ: begin
                if (mem_ready) begin
                    dDataNext   = mem_rdata;
                    memReadNext = 1'b0;
                    dReadyNext  = 1'b1;
                    stateNext   = RESP;
                end
            end

            D_WRITE: begin
                if (mem_ready) begin
                    memWriteNext    = 1'b0;
                    dWriteReadyNext = 1'b1;
                    stateNext       = RESP;
                end
            end

            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state        <= IDLE;
            i_readready  <= 1'b0;
            i_data       <= '0;
            d_readready  <= 1'b0;
            d_writeready <= 1'b0;
            d_data       <= '0;
            mem_addr     <= '0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_wdata    <= '0;
            mem_abort    <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state        <= stateNext;
            i_readready  <= iReadyNext;
            i_data       <= iDataNext;
            d_readready  <= dReadyNext;
            d_writeready <= dWriteReadyNext;
            d_data       <= dDataNext;
            mem_addr     <= memAddrNext;
            mem_read     <= memReadNext;
            mem_write    <= memWriteNext;
            mem_wdata    <= memWdataNext;
            mem_abort    <= memAbortNext;
            timeout_err  <= timeoutNext;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized request mixes
// checked against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned LINE_W   = 128;
    localparam int unsigned WORD_W   = 32;
    localparam int          FAIR_MAX = 4;
    localparam int unsigned TIMEOUT  = 64;

    logic              Clk;
    logic              Rst;
    logic              i_readmiss;
    logic [ADDR_W-1:0] i_addr;
    logic              i_abort;
    logic              i_readready;
    logic [LINE_W-1:0] i_data;
    logic              d_readmiss;
    logic              d_writethru;
    logic [ADDR_W-1:0] d_addr;
    logic [WORD_W-1:0] d_wdata;
    logic              d_readready;
    logic              d_writeready;
    logic [LINE_W-1:0] d_data;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read;
    logic              mem_write;
    logic [WORD_W-1:0] mem_wdata;
    logic              mem_abort;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              timeout_err;

    mem_port_arbiter #(
        .ADDR_W   (ADDR_W),
        .LINE_W   (LINE_W),
        .WORD_W   (WORD_W),
        .FAIR_MAX (FAIR_MAX),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .i_readmiss   (i_readmiss),
        .i_addr       (i_addr),
        .i_abort      (i_abort),
        .i_readready  (i_readready),
        .i_data       (i_data),
        .d_readmiss   (d_readmiss),
        .d_writethru  (d_writethru),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_readready  (d_readready),
        .d_writeready (d_writeready),
        .d_data       (d_data),
        .mem_addr     (mem_addr),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_wdata    (mem_wdata),
        .mem_abort    (mem_abort),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .timeout_err  (timeout_err)
    );

    int                vectors     = 0;
    int                miscompares = 0;
    int                memLat      = 0;
    int                memCnt      = 0;
    int                overlapCnt  = 0;
    int                abortCnt    = 0;
    int                readyCnt    = 0;
    int                modelStreak = 0;
    logic [LINE_W-1:0] memData     = '0;
    logic [LINE_W-1:0] lastI       = '0;
    logic [LINE_W-1:0] lastD       = '0;
    logic              errAt64     = 1'bx;
    logic              errAt65     = 1'bx;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] randLine();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [511:0] allOut();
        return 512'({i_readready, i_data, d_readready, d_writeready, d_data, mem_addr,
                     mem_read, mem_write, mem_wdata, mem_abort, timeout_err});
    endfunction

    function automatic logic [2:0] readyOf(input arb_src_t s);
        case (s)
            SRC_I:    return 3'b100;
            SRC_D_RD: return 3'b010;
            SRC_D_WR: return 3'b001;
            default:  return 3'b000;
        endcase
    endfunction

    // One clock; memory answers in the memLat-th consecutive busy cycle.
    task automatic tick();
        @(posedge Clk);
        #1;
        if (mem_read && mem_write) overlapCnt++;
        if (mem_abort) abortCnt++;
        if (i_readready || d_readready || d_writeready) readyCnt++;
        if (mem_read || mem_write) memCnt++;
        else memCnt = 0;
        if (memCnt == 64) errAt64 = timeout_err;
        if (memCnt == 65) errAt65 = timeout_err;
        mem_ready = (memCnt != 0) && (memCnt == memLat);
        mem_rdata = mem_ready ? memData : randLine();
    endtask

    task automatic resetDut(input int cycles);
        Rst         = 1'b1;
        i_readmiss  = 1'b0;
        i_abort     = 1'b0;
        d_readmiss  = 1'b0;
        d_writethru = 1'b0;
        memLat      = 0;
        repeat (cycles) tick();
        Rst         = 1'b0;
        modelStreak = 0;
        lastI       = '0;
        lastD       = '0;
    endtask

    function automatic arb_src_t pick(input bit pI, input bit pW, input bit pR);
        if (pI && modelStreak == FAIR_MAX) return SRC_I;
        if (pW) return SRC_D_WR;
        if (pR) return SRC_D_RD;
        return SRC_I;
    endfunction

    task automatic account(input arb_src_t w, input bit pI);
        if (w == SRC_I || !pI) modelStreak = 0;
        else if (modelStreak < FAIR_MAX) modelStreak++;
    endtask

    // Waits for the grant of 'exp', answers it after 'lat' busy cycles, checks the pulse.
    task automatic serve(input arb_src_t exp, input int lat, input logic [LINE_W-1:0] data);
        int n;
        int l;
        l       = (lat != 0) ? lat : int'($urandom_range(1, 6));
        memLat  = l;
        memData = data;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(mem_read || mem_write) && n < 10);
        check("grant_latency", 512'(n), 512'(1));
        check("grant_kind", 512'({mem_write, mem_read}),
              512'((exp == SRC_D_WR) ? 2'b10 : 2'b01));
        check("mem_addr", 512'(mem_addr), 512'((exp == SRC_I) ? i_addr : d_addr));
        if (exp == SRC_D_WR) check("mem_wdata", 512'(mem_wdata), 512'(d_wdata));
        n = 0;
        while (!(i_readready || d_readready || d_writeready) && n < l + 40) begin
            tick();
            n++;
        end
        check("ready_latency", 512'(n), 512'(l));
        check("ready_which", 512'({i_readready, d_readready, d_writeready}), 512'(readyOf(exp)));
        check("bus_idle_resp", 512'({mem_read, mem_write}), 512'(0));
        if (exp == SRC_I) lastI = data;
        if (exp == SRC_D_RD) lastD = data;
        check("i_data", 512'(i_data), 512'(lastI));
        check("d_data", 512'(d_data), 512'(lastD));
        case (exp)
            SRC_I:    i_readmiss  = 1'b0;
            SRC_D_RD: d_readmiss  = 1'b0;
            default:  d_writethru = 1'b0;
        endcase
        tick();
        check("ready_single", 512'({i_readready, d_readready, d_writeready}), 512'(0));
    endtask

    task automatic serveSet(input bit rI, input bit rW, input bit rR,
                            input logic [ADDR_W-1:0] ia, input logic [ADDR_W-1:0] da,
                            input logic [WORD_W-1:0] wd, input int lat,
                            input logic [LINE_W-1:0] data);
        bit       pI;
        bit       pW;
        bit       pR;
        arb_src_t w;
        int       k;
        pI = rI; pW = rW; pR = rR; k = 0;
        i_addr      = ia;
        d_addr      = da;
        d_wdata     = wd;
        i_readmiss  = rI;
        d_writethru = rW;
        d_readmiss  = rR;
        while ((pI || pW || pR) && k < 4) begin
            w = pick(pI, pW, pR);
            account(w, pI);
            serve(w, lat, (k == 0) ? data : randLine());
            case (w)
                SRC_I:    pI = 1'b0;
                SRC_D_WR: pW = 1'b0;
                default:  pR = 1'b0;
            endcase
            k++;
        end
    endtask

    initial begin
        arb_src_t w;
        bit       pI;
        bit       rI;
        bit       rW;
        bit       rR;
        Rst = 1'b1; i_readmiss = 1'b0; i_addr = '0; i_abort = 1'b0;
        d_readmiss = 1'b0; d_writethru = 1'b0; d_addr = '0; d_wdata = '0;
        mem_rdata = '0; mem_ready = 1'b0;

        // Reset held 3 cycles, then idle with no requests.
        resetDut(3);
        Rst = 1'b1;
        check("reset_outputs", allOut(), 512'(0));
        Rst = 1'b0;
        tick();
        check("idle_outputs", allOut(), 512'(0));

        // Single icache fill, latency 5.
        serveSet(1'b1, 1'b0, 1'b0, 32'h0040_0010, 32'h0, 32'h0, 5, {4{32'hA5A5_A5A5}});

        // Write-through and icache miss together: write first.
        serveSet(1'b1, 1'b1, 1'b0, 32'h0000_1000, 32'h0000_2004, 32'hDEAD_BEEF, 3, randLine());
        check("no_overlap", 512'(overlapCnt), 512'(0));

        // Back-to-back dcache misses with icache held.
        resetDut(1);
        i_addr = 32'h0000_3000; d_addr = 32'h0000_4000;
        i_readmiss = 1'b1; d_readmiss = 1'b1; pI = 1'b1;
        for (int j = 0; j < 6; j++) begin
            w = pick(pI, 1'b0, 1'b1);
            account(w, pI);
            serve(w, 2, randLine());
            if (w == SRC_I) pI = 1'b0;
            else if (j < 5) d_readmiss = 1'b1;
        end

        // Abort two cycles into an icache fill.
        resetDut(1);
        abortCnt = 0; readyCnt = 0;
        i_addr = 32'h0000_5000; i_readmiss = 1'b1; memLat = 50;
        tick();
        check("abort_busy", 512'(mem_read), 512'(1));
        tick();
        i_abort = 1'b1; i_readmiss = 1'b0;
        tick();
        i_abort = 1'b0;
        check("abort_pulse", 512'({mem_abort, mem_read, i_readready}), 512'(3'b100));
        tick();
        check("abort_single", 512'({mem_abort, mem_read}), 512'(0));
        repeat (3) tick();
        check("abort_no_ready", 512'(readyCnt), 512'(0));

        // Abort coinciding with mem_ready: data discarded.
        memLat = 2; memData = randLine(); i_readmiss = 1'b1;
        tick();
        tick();
        i_abort = 1'b1; i_readmiss = 1'b0;
        tick();
        i_abort = 1'b0;
        check("abort_vs_ready", 512'({mem_abort, i_readready}), 512'(2'b10));
        repeat (2) tick();
        check("abort_data_held", 512'(i_data), 512'(lastI));
        check("abort_ready_cnt", 512'(readyCnt), 512'(0));

        // i_abort outside I_READ is ignored.
        abortCnt = 0;
        i_abort = 1'b1;
        serveSet(1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_6000, 32'h0, 3, randLine());
        i_abort = 1'b0;
        check("abort_ignored", 512'(abortCnt), 512'(0));

        // Randomized request mixes.
        for (int r = 0; r < 30; r++) begin
            rI = 1'($urandom); rW = 1'($urandom); rR = 1'($urandom);
            if (!(rI || rW || rR)) rR = 1'b1;
            serveSet(rI, rW, rR, $urandom, $urandom, $urandom, 0, randLine());
            repeat ($urandom_range(0, 2)) tick();
        end
        check("no_overlap_rand", 512'(overlapCnt), 512'(0));
        check("no_timeout_yet", 512'(timeout_err), 512'(0));

        // Timeout: memory stalls 70 busy cycles, then completes.
        resetDut(1);
        serveSet(1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_7000, 32'h0, 70, randLine());
        check("timeout_at_64", 512'(errAt64), 512'(0));
        check("timeout_at_65", 512'(errAt65), 512'(1));
        repeat (3) tick();
        check("timeout_sticky", 512'(timeout_err), 512'(1));

        // Reset in the middle of a dcache fill.
        d_addr = 32'h0000_8000; d_readmiss = 1'b1; memLat = 50; readyCnt = 0;
        repeat (3) tick();
        Rst = 1'b1; d_readmiss = 1'b0;
        tick();
        check("rst_mid_outputs", allOut(), 512'(0));
        Rst = 1'b0;
        repeat (3) tick();
        check("rst_mid_no_ready", 512'(readyCnt), 512'(0));
        check("rst_mid_idle", allOut(), 512'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
